// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - decode/scoreboard handshake bundle
// Purpose: groups the issue, writeback, flush and hazard-result signals
//          between the decode stage (master) and the scoreboard (slave).
// Signals: issue_valid, src_reg[NSRC*RW], src_valid[NSRC], src_late[NSRC],
//          dest_reg[RW], dest_valid, dest_lat[LW], wb_valid, wb_reg[RW], flush
//          (master -> slave); stall, src_fwd[NSRC], busy_vec[NREGS],
//          stall_cycles[32] (slave -> master).
interface hazard_scoreboard_if #(
   parameter int NREGS   = 32,
   parameter int NSRC    = 2,
   parameter int MAX_LAT = 8,
   parameter int RW      = $clog2(NREGS),
   parameter int LW      = $clog2(MAX_LAT + 1)
);
   logic                 issue_valid;
   logic [NSRC*RW-1:0]   src_reg;
   logic [NSRC-1:0]      src_valid;
   logic [NSRC-1:0]      src_late;
   logic [RW-1:0]        dest_reg;
   logic                 dest_valid;
   logic [LW-1:0]        dest_lat;
   logic                 wb_valid;
   logic [RW-1:0]        wb_reg;
   logic                 flush;
   logic                 stall;
   logic [NSRC-1:0]      src_fwd;
   logic [NREGS-1:0]     busy_vec;
   logic [31:0]          stall_cycles;

   modport master (
      output issue_valid, src_reg, src_valid, src_late, dest_reg, dest_valid,
             dest_lat, wb_valid, wb_reg, flush,
      input  stall, src_fwd, busy_vec, stall_cycles
   );

   modport slave (
      input  issue_valid, src_reg, src_valid, src_late, dest_reg, dest_valid,
             dest_lat, wb_valid, wb_reg, flush,
      output stall, src_fwd, busy_vec, stall_cycles
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - per-register decode hazard scoreboard
// Purpose: tracks every in-flight register write with a countdown until its
//          result reaches a bypass, and from that produces the decode stall,
//          per-source forward flags and a saturating stall-cycle counter.
// Ports:   i_clock    - rising-edge clock
//          i_reset_n  - asynchronous active-low reset
//          sb         - hazard_scoreboard_if.slave (issue/writeback/flush in,
//                       stall/src_fwd/busy_vec/stall_cycles out)
module hazard_scoreboard #(
   parameter int NREGS   = 32,
   parameter int NSRC    = 2,
   parameter int MAX_LAT = 8,
   parameter int RW      = $clog2(NREGS),
   parameter int LW      = $clog2(MAX_LAT + 1)
) (
   input  logic               i_clock,
   input  logic               i_reset_n,
   hazard_scoreboard_if.slave sb
);

   logic [NREGS-1:0] r_busy;
   logic [LW-1:0]    r_rem [NREGS];
   logic [31:0]      r_stall_cycles;

   logic [LW-1:0]    w_lat;
   logic [NSRC-1:0]  w_src_haz;
   logic [NSRC-1:0]  w_src_busy;
   logic             w_waw;
   logic             w_stall;
   logic             w_accept;
   logic             w_alloc;

   // rem is loaded with the full latency and counts down to the cycle the
   // result sits on the bypass. The hazard checks look at the cycles still to
   // wait beyond the current one, so a latency-1 producer can feed the very
   // next instruction through the bypass.
   function automatic logic [LW-1:0] wait_of(input logic [LW-1:0] rem);
      return (rem == '0) ? '0 : rem - LW'(1);
   endfunction

   always_comb begin
      if (sb.dest_lat == '0)
         w_lat = LW'(1);
      else if (sb.dest_lat > LW'(MAX_LAT))
         w_lat = LW'(MAX_LAT);
      else
         w_lat = sb.dest_lat;
   end

   always_comb begin
      logic [RW-1:0] s;
      w_src_haz  = '0;
      w_src_busy = '0;
      for (int i = 0; i < NSRC; i++) begin
         s = sb.src_reg[i*RW +: RW];
         if (sb.src_valid[i] && s != '0 && r_busy[s]) begin
            w_src_busy[i] = 1'b1;
            // A late-needed operand can tolerate one extra cycle of wait.
            if (wait_of(r_rem[s]) > (sb.src_late[i] ? LW'(1) : LW'(0)))
               w_src_haz[i] = 1'b1;
         end
      end
   end

   // A new write must not complete before an older write to the same register.
   assign w_waw = sb.dest_valid && sb.dest_reg != '0 && r_busy[sb.dest_reg] &&
                  wait_of(r_rem[sb.dest_reg]) >= w_lat;

   assign w_stall  = sb.issue_valid && !sb.flush && (|w_src_haz || w_waw);
   assign w_accept = sb.issue_valid && !w_stall && !sb.flush;
   assign w_alloc  = w_accept && sb.dest_valid && sb.dest_reg != '0;

   assign sb.stall        = w_stall;
   assign sb.src_fwd      = w_src_busy & {NSRC{~w_stall}};
   assign sb.busy_vec     = r_busy;
   assign sb.stall_cycles = r_stall_cycles;

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_busy         <= '0;
         r_stall_cycles <= '0;
         for (int i = 0; i < NREGS; i++)
            r_rem[i] <= '0;
      end else begin
         if (w_stall && r_stall_cycles != 32'hFFFF_FFFF)
            r_stall_cycles <= r_stall_cycles + 32'd1;

         // Priority per entry: flush, new allocation (wins over a same-cycle
         // writeback and replaces any decrement), writeback, countdown.
         for (int i = 0; i < NREGS; i++) begin
            if (i == 0 || sb.flush) begin
               r_busy[i] <= 1'b0;
               r_rem[i]  <= '0;
            end else if (w_alloc && sb.dest_reg == RW'(i)) begin
               r_busy[i] <= 1'b1;
               r_rem[i]  <= w_lat;
            end else if (sb.wb_valid && sb.wb_reg == RW'(i)) begin
               r_busy[i] <= 1'b0;
               r_rem[i]  <= '0;
            end else if (r_rem[i] != '0) begin
               r_rem[i]  <= r_rem[i] - LW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   hazard_scoreboard_if sb_if ();

   hazard_scoreboard dut (
      .i_clock   (clk),
      .i_reset_n (rst_n),
      .sb        (sb_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      sb_if.issue_valid = 1'b0;
      sb_if.src_reg     = '0;
      sb_if.src_valid   = '0;
      sb_if.src_late    = '0;
      sb_if.dest_reg    = '0;
      sb_if.dest_valid  = 1'b0;
      sb_if.dest_lat    = '0;
      sb_if.wb_valid    = 1'b0;
      sb_if.wb_reg      = '0;
      sb_if.flush       = 1'b0;
   endtask

   task automatic set_issue(input logic [4:0] s1, input logic [4:0] s0,
                            input logic [1:0] sv, input logic [1:0] late,
                            input logic [4:0] d, input logic dv, input logic [3:0] lat);
      idle();
      sb_if.issue_valid = 1'b1;
      sb_if.src_reg     = {s1, s0};
      sb_if.src_valid   = sv;
      sb_if.src_late    = late;
      sb_if.dest_reg    = d;
      sb_if.dest_valid  = dv;
      sb_if.dest_lat    = lat;
   endtask

   task automatic clear_sb;
      idle();
      sb_if.flush = 1'b1;
      step();
      idle();
   endtask

   task automatic test_reset;
      idle();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
      @(negedge clk);
      total++; if (sb_if.busy_vec !== 32'h0) begin bad++; $display("FAIL reset_busy got=%h exp=%h", sb_if.busy_vec, 32'h0); end
      total++; if (sb_if.stall_cycles !== 32'd0) begin bad++; $display("FAIL reset_stall_cycles got=%0d exp=0", sb_if.stall_cycles); end
      total++; if (sb_if.stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", sb_if.stall); end
      step();
   endtask

   task automatic test_back_to_back;
      set_issue(5'd0, 5'd0, 2'b00, 2'b00, 5'd3, 1'b1, 4'd1);
      @(negedge clk);
      total++; if (sb_if.stall !== 1'b0) begin bad++; $display("FAIL b2b_producer_stall got=%b exp=0", sb_if.stall); end
      step();
      set_issue(5'd0, 5'd3, 2'b01, 2'b00, 5'd0, 1'b0, 4'd0);
      @(negedge clk);
      total++; if (sb_if.stall !== 1'b0) begin bad++; $display("FAIL b2b_stall got=%b exp=0", sb_if.stall); end
      total++; if (sb_if.src_fwd !== 2'b01) begin bad++; $display("FAIL b2b_fwd got=%b exp=01", sb_if.src_fwd); end
      step();
      idle();
      step();
      step();
      total++; if (sb_if.busy_vec !== 32'h0000_0008) begin bad++; $display("FAIL b2b_hold_busy got=%h exp=%h", sb_if.busy_vec, 32'h8); end
      sb_if.wb_valid = 1'b1;
      sb_if.wb_reg   = 5'd3;
      step();
      idle();
      total++; if (sb_if.busy_vec !== 32'h0) begin bad++; $display("FAIL b2b_wb_clear got=%h exp=0", sb_if.busy_vec); end
   endtask

   task automatic test_load_use;
      set_issue(5'd0, 5'd0, 2'b00, 2'b00, 5'd5, 1'b1, 4'd2);
      step();
      set_issue(5'd0, 5'd5, 2'b01, 2'b00, 5'd0, 1'b0, 4'd0);
      @(negedge clk);
      total++; if (sb_if.stall !== 1'b1) begin bad++; $display("FAIL load_use_stall got=%b exp=1", sb_if.stall); end
      total++; if (sb_if.src_fwd !== 2'b00) begin bad++; $display("FAIL load_use_fwd_during_stall got=%b exp=00", sb_if.src_fwd); end
      step();
      @(negedge clk);
      total++; if (sb_if.stall !== 1'b0) begin bad++; $display("FAIL load_use_release got=%b exp=0", sb_if.stall); end
      total++; if (sb_if.src_fwd !== 2'b01) begin bad++; $display("FAIL load_use_fwd got=%b exp=01", sb_if.src_fwd); end
      total++; if (sb_if.stall_cycles !== 32'd1) begin bad++; $display("FAIL load_use_count got=%0d exp=1", sb_if.stall_cycles); end
      step();
      clear_sb();
   endtask

   task automatic test_store_after_load;
      set_issue(5'd0, 5'd0, 2'b00, 2'b00, 5'd5, 1'b1, 4'd2);
      step();
      set_issue(5'd5, 5'd0, 2'b10, 2'b10, 5'd0, 1'b0, 4'd0);
      @(negedge clk);
      total++; if (sb_if.stall !== 1'b0) begin bad++; $display("FAIL store_stall got=%b exp=0", sb_if.stall); end
      total++; if (sb_if.src_fwd !== 2'b10) begin bad++; $display("FAIL store_fwd got=%b exp=10", sb_if.src_fwd); end
      step();
      clear_sb();
   endtask

   task automatic test_divide;
      int n;
      set_issue(5'd0, 5'd0, 2'b00, 2'b00, 5'd8, 1'b1, 4'd8);
      step();
      set_issue(5'd0, 5'd8, 2'b01, 2'b00, 5'd0, 1'b0, 4'd0);
      n = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (!sb_if.stall) break;
         n++;
         step();
      end
      total++; if (n !== 7) begin bad++; $display("FAIL div_src_stalls got=%0d exp=7", n); end
      total++; if (sb_if.src_fwd !== 2'b01) begin bad++; $display("FAIL div_src_fwd got=%b exp=01", sb_if.src_fwd); end
      total++; if (sb_if.stall_cycles !== 32'd8) begin bad++; $display("FAIL div_src_count got=%0d exp=8", sb_if.stall_cycles); end
      step();
      clear_sb();

      set_issue(5'd0, 5'd0, 2'b00, 2'b00, 5'd8, 1'b1, 4'd8);
      step();
      set_issue(5'd0, 5'd0, 2'b00, 2'b00, 5'd8, 1'b1, 4'd1);
      n = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (!sb_if.stall) break;
         n++;
         step();
      end
      total++; if (n !== 7) begin bad++; $display("FAIL div_waw_stalls got=%0d exp=7", n); end
      total++; if (sb_if.stall_cycles !== 32'd15) begin bad++; $display("FAIL div_waw_count got=%0d exp=15", sb_if.stall_cycles); end
      step();
      idle();
      total++; if (sb_if.busy_vec !== 32'h0000_0100) begin bad++; $display("FAIL div_waw_busy got=%h exp=%h", sb_if.busy_vec, 32'h100); end
      clear_sb();
   endtask

   task automatic test_same_cycle;
      set_issue(5'd0, 5'd0, 2'b00, 2'b00, 5'd4, 1'b1, 4'd1);
      step();
      set_issue(5'd0, 5'd0, 2'b00, 2'b00, 5'd4, 1'b1, 4'd3);
      sb_if.wb_valid = 1'b1;
      sb_if.wb_reg   = 5'd4;
      @(negedge clk);
      total++; if (sb_if.stall !== 1'b0) begin bad++; $display("FAIL conflict_stall got=%b exp=0", sb_if.stall); end
      step();
      idle();
      total++; if (sb_if.busy_vec !== 32'h0000_0010) begin bad++; $display("FAIL conflict_busy got=%h exp=%h", sb_if.busy_vec, 32'h10); end
      set_issue(5'd0, 5'd4, 2'b01, 2'b00, 5'd6, 1'b1, 4'd2);
      sb_if.flush = 1'b1;
      @(negedge clk);
      total++; if (sb_if.stall !== 1'b0) begin bad++; $display("FAIL flush_stall got=%b exp=0", sb_if.stall); end
      step();
      idle();
      total++; if (sb_if.busy_vec !== 32'h0) begin bad++; $display("FAIL flush_busy got=%h exp=0", sb_if.busy_vec); end
      total++; if (sb_if.stall_cycles !== 32'd15) begin bad++; $display("FAIL flush_keeps_count got=%0d exp=15", sb_if.stall_cycles); end
   endtask

   task automatic test_reg0;
      set_issue(5'd0, 5'd0, 2'b11, 2'b00, 5'd0, 1'b1, 4'd3);
      @(negedge clk);
      total++; if (sb_if.stall !== 1'b0) begin bad++; $display("FAIL r0_stall got=%b exp=0", sb_if.stall); end
      total++; if (sb_if.src_fwd !== 2'b00) begin bad++; $display("FAIL r0_fwd got=%b exp=00", sb_if.src_fwd); end
      step();
      idle();
      total++; if (sb_if.busy_vec !== 32'h0) begin bad++; $display("FAIL r0_busy got=%h exp=0", sb_if.busy_vec); end
   endtask

   task automatic test_reset_mid;
      set_issue(5'd0, 5'd0, 2'b00, 2'b00, 5'd8, 1'b1, 4'd8);
      step();
      set_issue(5'd0, 5'd8, 2'b01, 2'b00, 5'd0, 1'b0, 4'd0);
      @(negedge clk);
      total++; if (sb_if.stall !== 1'b1) begin bad++; $display("FAIL mid_pre_stall got=%b exp=1", sb_if.stall); end
      #2;
      rst_n = 1'b0;
      #1;
      total++; if (sb_if.busy_vec !== 32'h0) begin bad++; $display("FAIL mid_reset_busy got=%h exp=0", sb_if.busy_vec); end
      total++; if (sb_if.stall !== 1'b0) begin bad++; $display("FAIL mid_reset_stall got=%b exp=0", sb_if.stall); end
      total++; if (sb_if.stall_cycles !== 32'd0) begin bad++; $display("FAIL mid_reset_count got=%0d exp=0", sb_if.stall_cycles); end
      idle();
      step();
      rst_n = 1'b1;
      step();
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      idle();
      test_reset();
      test_back_to_back();
      test_load_use();
      test_store_after_load();
      test_divide();
      test_same_cycle();
      test_reg0();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

endmodule
